// File: rtl/popcount_arbiter.sv
// Round-robin arbiter sharing one combinational ones_counter among NUM_REQ requesters.
// Optional build macro POPCNT_ARB_LOCK_EN adds req_last and multi-word lock to one requester.

module ones_counter #(
    parameter  int DATA_WIDTH = 8,
    localparam int CW         = $clog2(DATA_WIDTH) + 1
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CW-1:0]         count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

module popcount_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    localparam int CW         = $clog2(DATA_WIDTH) + 1,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef POPCNT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [CW-1:0]                 res_count,
    output logic [IW-1:0]                 res_id,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] op_reg;
    logic [IW-1:0]         id_reg;
    logic [IW-1:0]         rr_ptr;
    logic                  rr_found;
    logic [IW-1:0]         rr_idx;
    logic                  grant_found;
    logic [IW-1:0]         grant_idx;
    logic [IW-1:0]         ptr_after_grant;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [CW-1:0]         counter_out;
    logic                  handshake;
    int                    search_idx;
`ifdef POPCNT_ARB_LOCK_EN
    logic                  lock_active;
    logic [IW-1:0]         lock_id;
`endif

    ones_counter #(.DATA_WIDTH(DATA_WIDTH)) u_counter (
        .data  (op_reg),
        .count (counter_out)
    );

    // Search starts at rr_ptr and wraps, so the requester after the last winner has top priority.
    always_comb begin
        rr_found   = 1'b0;
        rr_idx     = '0;
        search_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!rr_found && req_valid[search_idx]) begin
                rr_found = 1'b1;
                rr_idx   = search_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        grant_found = rr_found;
        grant_idx   = rr_idx;
`ifdef POPCNT_ARB_LOCK_EN
        if (lock_active) begin
            grant_found = req_valid[lock_id];
            grant_idx   = lock_id;
        end
`endif
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(grant_idx) == i) begin
                grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ptr_after_grant = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

    assign handshake = (state == IDLE) && grant_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = COUNT;
            COUNT:   state_next = HOLD;
            HOLD:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_idx] = 1'b1;
        end
        busy = (state != IDLE);
    end

    // Reset drops any in-flight word and restarts the search from requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg    <= '0;
            id_reg    <= '0;
            rr_ptr    <= '0;
            res_count <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
`ifdef POPCNT_ARB_LOCK_EN
            lock_active <= 1'b0;
            lock_id     <= '0;
`endif
        end else begin
            if (handshake) begin
                op_reg <= grant_data;
                id_reg <= grant_idx;
`ifdef POPCNT_ARB_LOCK_EN
                if (req_last[grant_idx]) begin
                    lock_active <= 1'b0;
                    rr_ptr      <= ptr_after_grant;
                end else begin
                    lock_active <= 1'b1;
                    lock_id     <= grant_idx;
                end
`else
                rr_ptr <= ptr_after_grant;
`endif
            end
            if (state == COUNT) begin
                res_count <= counter_out;
                res_id    <= id_reg;
                res_valid <= 1'b1;
            end
            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed-vector bench for popcount_arbiter (DATA_WIDTH=8, NUM_REQ=4).
// The lock scenario is compiled in only when POPCNT_ARB_LOCK_EN is defined.

module tb_popcount_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
`ifdef POPCNT_ARB_LOCK_EN
    logic [3:0]  req_last;
`endif
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_count;
    logic [1:0]  res_id;
    logic        busy;

    int checks = 0;
    int passes = 0;

    popcount_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef POPCNT_ARB_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
`ifdef POPCNT_ARB_LOCK_EN
        req_last  = '1;
`endif
        step();
        step();
        checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready: got %b want %b", req_ready, 4'b0000); else passes++;
        checks++; if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b want 0", res_valid); else passes++;
        checks++; if (res_count !== 4'd0) $display("[TB] FAIL reset_res_count: got %0d want 0", res_count); else passes++;
        checks++; if (res_id !== 2'd0) $display("[TB] FAIL reset_res_id: got %0d want 0", res_id); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_data[16 +: 8] = 8'b0000_0111;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL single_grant: got %b want %b", req_ready, 4'b0100); else passes++;
        step();
        req_valid = 4'b0000;
        checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL single_count_ready: got %b want 0000", req_ready); else passes++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b want 1", busy); else passes++;
        checks++; if (res_valid !== 1'b0) $display("[TB] FAIL single_early_valid: got %b want 0", res_valid); else passes++;
        step();
        checks++; if (res_valid !== 1'b1) $display("[TB] FAIL single_valid: got %b want 1", res_valid); else passes++;
        checks++; if (res_count !== 4'd3) $display("[TB] FAIL single_count: got %0d want 3", res_count); else passes++;
        checks++; if (res_id !== 2'd2) $display("[TB] FAIL single_id: got %0d want 2", res_id); else passes++;
        res_ready = 1'b1;
        step();
        checks++; if (res_valid !== 1'b0) $display("[TB] FAIL single_release_valid: got %b want 0", res_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL single_release_busy: got %b want 0", busy); else passes++;
        res_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_cnt [4];
        logic [3:0] exp_ready;
        exp_cnt[0] = 4'd0;
        exp_cnt[1] = 4'd1;
        exp_cnt[2] = 4'd8;
        exp_cnt[3] = 4'd4;
        do_reset();
        req_data  = {8'h0F, 8'hFF, 8'h01, 8'h00};
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_ready = 4'b0001 << k;
            checks++; if (req_ready !== exp_ready) $display("[TB] FAIL simul_grant%0d: got %b want %b", k, req_ready, exp_ready); else passes++;
            step();
            req_valid[k] = 1'b0;
            step();
            checks++; if (res_valid !== 1'b1) $display("[TB] FAIL simul_valid%0d: got %b want 1", k, res_valid); else passes++;
            checks++; if (res_id !== 2'(k)) $display("[TB] FAIL simul_id%0d: got %0d want %0d", k, res_id, k); else passes++;
            checks++; if (res_count !== exp_cnt[k]) $display("[TB] FAIL simul_count%0d: got %0d want %0d", k, res_count, exp_cnt[k]); else passes++;
            step();
        end
        res_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        req_data[16 +: 8] = 8'hFF;
        req_valid = 4'b0100;
        res_ready = 1'b0;
        step();
        req_data[0 +: 8] = 8'h01;
        req_valid = 4'b0001;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++; if (res_valid !== 1'b1) $display("[TB] FAIL bp_valid%0d: got %b want 1", c, res_valid); else passes++;
            checks++; if (res_count !== 4'd8) $display("[TB] FAIL bp_count%0d: got %0d want 8", c, res_count); else passes++;
            checks++; if (res_id !== 2'd2) $display("[TB] FAIL bp_id%0d: got %0d want 2", c, res_id); else passes++;
            checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL bp_ready%0d: got %b want 0000", c, req_ready); else passes++;
            step();
        end
        req_valid = 4'b0000;
        res_ready = 1'b1;
        step();
        checks++; if (res_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b want 0", res_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL bp_release_busy: got %b want 0", busy); else passes++;
        res_ready = 1'b0;
    endtask

    task automatic test_rr_wrap();
        res_ready = 1'b1;
        req_data[24 +: 8] = 8'h80;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) $display("[TB] FAIL wrap_first3: got %b want 1000", req_ready); else passes++;
        step();
        req_valid = 4'b0000;
        step();
        checks++; if (res_id !== 2'd3) $display("[TB] FAIL wrap_id3a: got %0d want 3", res_id); else passes++;
        step();
        req_data[0 +: 8]  = 8'h03;
        req_data[24 +: 8] = 8'h3F;
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL wrap_grant0: got %b want 0001", req_ready); else passes++;
        step();
        req_valid[0] = 1'b0;
        step();
        checks++; if (res_id !== 2'd0) $display("[TB] FAIL wrap_id0: got %0d want 0", res_id); else passes++;
        checks++; if (res_count !== 4'd2) $display("[TB] FAIL wrap_count0: got %0d want 2", res_count); else passes++;
        step();
        checks++; if (req_ready !== 4'b1000) $display("[TB] FAIL wrap_grant3: got %b want 1000", req_ready); else passes++;
        step();
        req_valid = 4'b0000;
        step();
        checks++; if (res_id !== 2'd3) $display("[TB] FAIL wrap_id3b: got %0d want 3", res_id); else passes++;
        checks++; if (res_count !== 4'd6) $display("[TB] FAIL wrap_count3: got %0d want 6", res_count); else passes++;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        req_data[16 +: 8] = 8'hAA;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL rmid_grant2: got %b want 0100", req_ready); else passes++;
        step();
        req_valid = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (res_valid !== 1'b0) $display("[TB] FAIL rmid_valid: got %b want 0", res_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rmid_busy: got %b want 0", busy); else passes++;
        checks++; if (res_count !== 4'd0) $display("[TB] FAIL rmid_count: got %0d want 0", res_count); else passes++;
        checks++; if (res_id !== 2'd0) $display("[TB] FAIL rmid_id: got %0d want 0", res_id); else passes++;
        step();
        checks++; if (res_valid !== 1'b0) $display("[TB] FAIL rmid_no_result: got %b want 0", res_valid); else passes++;
        req_data[8 +: 8]  = 8'h55;
        req_data[24 +: 8] = 8'h70;
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL rmid_grant1: got %b want 0010", req_ready); else passes++;
        step();
        req_valid[1] = 1'b0;
        step();
        checks++; if (res_id !== 2'd1) $display("[TB] FAIL rmid_id1: got %0d want 1", res_id); else passes++;
        checks++; if (res_count !== 4'd4) $display("[TB] FAIL rmid_count1: got %0d want 4", res_count); else passes++;
        step();
        checks++; if (req_ready !== 4'b1000) $display("[TB] FAIL rmid_grant3: got %b want 1000", req_ready); else passes++;
        step();
        req_valid = 4'b0000;
        step();
        checks++; if (res_id !== 2'd3) $display("[TB] FAIL rmid_id3: got %0d want 3", res_id); else passes++;
        checks++; if (res_count !== 4'd3) $display("[TB] FAIL rmid_count3: got %0d want 3", res_count); else passes++;
        step();
        res_ready = 1'b0;
    endtask

`ifdef POPCNT_ARB_LOCK_EN
    task automatic test_lock();
        logic [7:0] word1 [3];
        word1[0] = 8'h01;
        word1[1] = 8'h03;
        word1[2] = 8'h07;
        do_reset();
        res_ready = 1'b1;
        req_data[0 +: 8] = 8'h0F;
        req_last  = 4'b0001;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL lock_prime: got %b want 0001", req_ready); else passes++;
        step();
        req_valid = 4'b0000;
        step();
        step();
        for (int w = 0; w < 3; w++) begin
            req_data[8 +: 8] = word1[w];
            req_last  = (w == 2) ? 4'b0011 : 4'b0001;
            req_valid = 4'b0011;
            #1;
            checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL lock_grant%0d: got %b want 0010", w, req_ready); else passes++;
            step();
            step();
            checks++; if (res_id !== 2'd1) $display("[TB] FAIL lock_id%0d: got %0d want 1", w, res_id); else passes++;
            checks++; if (res_count !== 4'(w + 1)) $display("[TB] FAIL lock_count%0d: got %0d want %0d", w, res_count, w + 1); else passes++;
            step();
        end
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL lock_after_grant0: got %b want 0001", req_ready); else passes++;
        step();
        step();
        checks++; if (res_id !== 2'd0) $display("[TB] FAIL lock_after_id0: got %0d want 0", res_id); else passes++;
        checks++; if (res_count !== 4'd4) $display("[TB] FAIL lock_after_count0: got %0d want 4", res_count); else passes++;
        step();
        checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL lock_ptr_end: got %b want 0010", req_ready); else passes++;
        req_valid = 4'b0000;
        step();
        res_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_back_pressure();
        test_rr_wrap();
        test_reset_mid();
`ifdef POPCNT_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/popcount_arbiter.md
# popcount_arbiter

Round-robin arbiter and sequencer that shares one `ones_counter` instance among `NUM_REQ` requesters. Each requester presents a `DATA_WIDTH`-bit word with a valid/ready handshake. The block grants one word at a time, runs it through the shared `ones_counter` and returns the registered count tagged with the requester index. It sits between the client blocks that need population counts and the single combinational counter datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand width; passed to the internal `ones_counter`
- `NUM_REQ`, 4, number of requesters; legal values are 2 and up
- `CW`, `$clog2(DATA_WIDTH)+1` (derived, not overridable), count width
- `IW`, `$clog2(NUM_REQ)` (derived), requester index width

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester word valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready`  out  NUM_REQ  one-hot grant/accept strobe
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result consumer ready
- `res_count`  out  CW  number of ones in the accepted word
- `res_id`  out  IW  index of the requester that owns `res_count`
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- The FSM has three states: IDLE, COUNT and HOLD. Reset puts it in IDLE.
- **IDLE:**
  - Round-robin search starts at `rr_ptr` and wraps modulo `NUM_REQ`. The first requester i with `req_valid[i]=1` wins.
  - `req_ready[i]` is asserted combinationally in the same cycle. That cycle is the handshake.
  - On the handshake: latch `req_data` slice i into `op_reg`, latch i into `id_reg`, set `rr_ptr <= (i+1) % NUM_REQ`, and go to COUNT.
  - With no valid request, the block stays in IDLE with `req_ready` all zero.
- **COUNT:** `op_reg` drives the `ones_counter` input. Its output is registered into `res_count`, and `id_reg` is registered into `res_id`. Set `res_valid <= 1` and go to HOLD.
- **HOLD:**
  - `res_valid=1`. `res_count` and `res_id` are held stable.
  - When `res_ready=1`: clear `res_valid` on the next edge and go to IDLE.
  - No new request is granted in HOLD.
- **Outputs outside the handshake:**
  - `req_ready` is zero in COUNT and HOLD.
  - At most one bit of `req_ready` is ever set.
- **Requester rules:**
  - Requesters may drop `req_valid` before they are granted.
  - The block samples `req_data` only on the handshake cycle.
- **Arithmetic:** `res_count` ranges from 0 to `DATA_WIDTH` inclusive. It never saturates and never wraps.

## Timing
- **Reset values:**
  - `req_ready=0`, `res_valid=0`, `res_count=0`, `res_id=0`, `busy=0`.
  - `rr_ptr=0`, lock cleared, state IDLE.
- **Latency:** handshake at edge N, then `res_valid` is high from edge N+2.
- **Throughput:** one word per 3 cycles when `res_ready` is held at 1.
- **Back-pressure:** HOLD lasts as long as `res_ready=0`. Outputs do not change during that time.
- **Reset mid-operation** (COUNT or HOLD): the transaction is dropped. `res_valid` is 0 on the cycle after reset, and the next grant searches from index 0.
- **Simultaneous requests:** only the round-robin winner is granted. The others wait, with their `req_ready` held at 0.
- **Wrap-around:** after a grant to `NUM_REQ-1`, the search starts at 0.

## Configuration
- **Macro:** `POPCNT_ARB_LOCK_EN`
- **Defined:**
  - Adds input port `req_last`, width `NUM_REQ`, sampled on the handshake.
  - A handshake with `req_last[i]=0` sets the lock to requester i.
  - While the lock is set, IDLE grants only requester i and ignores all other requests. `rr_ptr` is not advanced.
  - A handshake with `req_last[i]=1` clears the lock and advances `rr_ptr` to `(i+1) % NUM_REQ`.
  - Reset clears the lock.
- **Undefined:**
  - The `req_last` port does not exist.
  - Every grant is a single-word transaction and `rr_ptr` advances on every grant.

## Test plan
- **Single request.** Requester 2 sends `8'b00000111` at edge N → `req_ready=4'b0100` at N, then `res_valid` at N+2 with `res_count=3` and `res_id=2`.
- **Simultaneous requests.** All four requesters are valid together with data `0x00`, `0x01`, `0xFF`, `0x0F` → results arrive in id order 0, 1, 2, 3 with counts 0, 1, 8, 4. Each result is 3 cycles apart with `res_ready=1`.
- **Back-pressure.** `res_ready=0` for 5 cycles in HOLD with `res_count=8` → `res_valid`, `res_count` and `res_id` stay constant and `req_ready` stays 0. Release `res_ready` → IDLE on the next edge.
- **Round-robin wrap.** After a grant to id 3, requesters 0 and 3 are both valid → id 0 is granted first, then id 3.
- **Reset in COUNT.** Assert `rst` during COUNT → `res_valid` never asserts for that word. All outputs take their reset values. With 1 and 3 then requesting, id 1 is granted first.
- **Lock (`POPCNT_ARB_LOCK_EN`).** Requester 1 sends 3 words with `req_last` = 0, 0, 1 while requester 0 is continuously valid → all 3 words are granted to id 1, then id 0 is granted. `rr_ptr` ends at 1.
